instruction_prefetch: RTL
=========================

# instruction_prefetch

Parametrised instruction fetch front end that replaces the single-entry IR/next-IR scheme with a DEPTH-entry prefetch queue. It fetches sequential words from the memory port, starting at BOOT_ADDR or at the last redirect target. It hands instructions with their PC and exception code to the backend through a valid/consume handshake. Sits between the memory arbiter and the decode stage; a backend redirect flushes the queue and discards any in-flight response.

## Interface

- DEPTH, 4: queue entries; power of two, ≥ 2.
- BOOT_ADDR, `BOOT_ADDR: first fetch address after reset.
- NOP, 32'h00000013: word driven on instr_Out while the queue is empty.

Ports:

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- redirect_In  in  1  flush queue and restart fetching at redirectPc_In.
- redirectPc_In  in  32  new fetch address; sampled when redirect_In=1.
- instrValid_Out  out  1  queue head holds a valid entry.
- instr_Out  out  32  head instruction; NOP when empty.
- instrPc_Out  out  32  PC of head instruction; 0 when empty.
- instrException_Out  out  `EXCEPTION_LEN  exception captured with head; 0 when empty.
- instrConsumed_In  in  1  backend takes head this cycle; ignored when instrValid_Out=0.
- memAddr_Out  out  32  fetch address; held stable while a request is outstanding.
- memData_Out  out  32  constant 0.
- memDataWidth_Out  out  2  constant `MEM_WIDTH_WORD.
- memIsRead_Out  out  1  constant 1.
- memAccess_Out  out  1  request strobe; = req_r && !memAccessOK_In.
- memAccessOK_In  in  1  one-cycle completion pulse; memData_In/memException_In valid with it.
- memData_In  in  32  fetched word.
- memException_In  in  `EXCEPTION_LEN  fetch exception code.

## Operation

State:
- Queue: data/pc/exception arrays, rd_ptr, wr_ptr (log2 DEPTH bits, wrap naturally), count (log2 DEPTH + 1 bits).
- fetch_pc; req_r (request outstanding); drop_r (outstanding response is stale).

Fetch FSM:
- IDLE: no request. Go to REQ when count < DEPTH and fetch is not halted. Load memAddr_Out=fetch_pc.
- REQ: memAccess_Out high and address held until memAccessOK_In.
  - On OK with drop_r=0: enqueue {memData_In, fetch_pc, memException_In}; fetch_pc += 4 (mod 2^32); go to IDLE.
  - On OK with drop_r=1: discard the response; clear drop_r; go to IDLE.
- At most one outstanding request. A request issues only when count < DEPTH, so an enqueue never overflows.

Queue behaviour:
- Dequeue occurs when instrValid_Out && instrConsumed_In.
- Enqueue and dequeue in the same cycle leave count unchanged.
- Full queue (count=DEPTH): no new request; fetching resumes the cycle after a dequeue.

Redirect:
- redirect_In=1: count, rd_ptr and wr_ptr clear next cycle; fetch_pc ← redirectPc_In.
- Redirect wins over a simultaneous consume or enqueue.
- If a request is outstanding and OK is not asserted that cycle: set drop_r. The memory access cannot be aborted, so the address stays held until OK arrives.
- Redirect in the same cycle as OK: the response is discarded.
- Repeated redirects while draining: the last target wins; drop_r stays set.
- No alignment check; redirectPc_In[1:0] is passed through unchanged.

Reset (rst=0):
- count=0, pointers 0, req_r=0, drop_r=0, fetch_pc=BOOT_ADDR, halt cleared.
- Outputs: instrValid_Out=0, instr_Out=NOP, instrPc_Out=0, instrException_Out=0, memAccess_Out=0, memAddr_Out=BOOT_ADDR.
- Reset mid-request abandons the request; the memory side is reset by the same signal.

## Timing

- First cycle after reset release: memAccess_Out=1, memAddr_Out=BOOT_ADDR.
- Empty queue, OK at cycle t: instrValid_Out=1 at t+1 with that word.
- OK at t, space remaining: next request (addr+4) at t+1. Throughput is one word per (memory latency + 1) cycles.
- Redirect at t with no request outstanding: memAccess_Out=1 at t+1 with the new address; instrValid_Out=0 at t+1.
- Redirect at t with a request outstanding: stale OK at t'; new request at t'+1.
- Consume of the head at t: the next entry appears at t+1.

## Configuration

- IFETCH_EXC_STOP_EN defined: enqueueing an entry with a nonzero exception sets halt. No further requests issue until redirect_In, which clears halt.
- IFETCH_EXC_STOP_EN undefined: exceptions are queued and sequential fetching continues at fetch_pc+4.

## Test plan

- Reset release, 1-cycle-latency memory returning addr as data, backend always consumes → requests at BOOT_ADDR, +4, +8; instr/PC pairs arrive in order with no loss.
- DEPTH=4, instrConsumed_In=0 → exactly 4 fetches; then memAccess_Out stays 0 and count=4. One consume → one new request the next cycle.
- Redirect to 0x00000100 while a request to 0x8 is pending; OK arrives 3 cycles later → 0x8 data dropped, next request addr=0x100, queue empty until it returns.
- Redirect, consume and OK in the same cycle, queue count=2 → count=0 next cycle, response discarded, fetch restarts at the redirect PC.
- memException_In=3 on the fetch of 0x10 → entry appears with exception 3. With IFETCH_EXC_STOP_EN no request follows until redirect; without it, 0x14 is fetched next.
- rst=0 asserted mid-request with 2 entries queued → next cycle all outputs at reset values, memAddr_Out=BOOT_ADDR.

Source files
------------

// File: rtl/instruction_prefetch.sv
// instruction_prefetch: DEPTH-entry sequential instruction prefetch queue with redirect flush.
// Optional IFETCH_EXC_STOP_EN: an enqueued exception halts fetching until the next redirect.
`ifndef BOOT_ADDR
`define BOOT_ADDR 32'h0000_0000
`endif
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif
`ifndef MEM_WIDTH_WORD
`define MEM_WIDTH_WORD 2'b10
`endif

module instruction_prefetch #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = `BOOT_ADDR,
    parameter logic [31:0] NOP       = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_In,
    input  logic [31:0]               redirectPc_In,
    output logic                      instrValid_Out,
    output logic [31:0]               instr_Out,
    output logic [31:0]               instrPc_Out,
    output logic [`EXCEPTION_LEN-1:0] instrException_Out,
    input  logic                      instrConsumed_In,
    output logic [31:0]               memAddr_Out,
    output logic [31:0]               memData_Out,
    output logic [1:0]                memDataWidth_Out,
    output logic                      memIsRead_Out,
    output logic                      memAccess_Out,
    input  logic                      memAccessOK_In,
    input  logic [31:0]               memData_In,
    input  logic [`EXCEPTION_LEN-1:0] memException_In
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                    state;
    logic [31:0]               data_q [DEPTH];
    logic [31:0]               pc_q   [DEPTH];
    logic [`EXCEPTION_LEN-1:0] exc_q  [DEPTH];
    logic [AW-1:0]             rd_ptr, wr_ptr;
    logic [AW:0]               count, count_n;
    logic [31:0]               fetch_pc, fetch_pc_n, mem_addr;
    logic                      drop_r, req_r, ok, hold, enq, deq, halt_n, issue;

    assign req_r      = state == REQ;
    assign ok         = req_r && memAccessOK_In;
    assign hold       = req_r && !memAccessOK_In;
    assign enq        = ok && !drop_r && !redirect_In;
    assign deq        = instrValid_Out && instrConsumed_In;
    assign count_n    = redirect_In ? '0 : count + (AW+1)'(enq) - (AW+1)'(deq);
    assign fetch_pc_n = redirect_In ? redirectPc_In : enq ? fetch_pc + 32'd4 : fetch_pc;
    // Issue decision uses next-cycle occupancy so a completion or consume restarts fetch immediately
    assign issue      = count_n < (AW+1)'(DEPTH) && !halt_n;

`ifdef IFETCH_EXC_STOP_EN
    logic halt;
    assign halt_n = redirect_In ? 1'b0 : halt || (enq && memException_In != '0);
    always_ff @(posedge clk)
        halt <= !rst ? 1'b0 : halt_n;
`else
    assign halt_n = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= BOOT_ADDR;
            mem_addr <= BOOT_ADDR;
            drop_r   <= 1'b0;
        end else begin
            state    <= hold || issue ? REQ : IDLE;
            mem_addr <= hold ? mem_addr : fetch_pc_n;
            fetch_pc <= fetch_pc_n;
            count    <= count_n;
            rd_ptr   <= redirect_In ? '0 : rd_ptr + AW'(deq);
            wr_ptr   <= redirect_In ? '0 : wr_ptr + AW'(enq);
            // An in-flight access cannot be cancelled, so a redirect only marks its response stale
            drop_r   <= hold ? drop_r || redirect_In : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && enq) begin
            data_q[wr_ptr] <= memData_In;
            pc_q[wr_ptr]   <= fetch_pc;
            exc_q[wr_ptr]  <= memException_In;
        end
    end

    assign instrValid_Out     = count != '0;
    assign instr_Out          = instrValid_Out ? data_q[rd_ptr] : NOP;
    assign instrPc_Out        = instrValid_Out ? pc_q[rd_ptr] : 32'd0;
    assign instrException_Out = instrValid_Out ? exc_q[rd_ptr] : '0;
    assign memAddr_Out        = mem_addr;
    assign memData_Out        = 32'd0;
    assign memDataWidth_Out   = `MEM_WIDTH_WORD;
    assign memIsRead_Out      = 1'b1;
    assign memAccess_Out      = hold;
endmodule
